// File: rtl/scope_trigger_capture_if.sv
// Bundle between the sample source, trigger controls and the column-reading consumer
// and scope_trigger_capture.
interface scope_trigger_capture_if #(
  parameter int VAL_RES = 16,
  parameter int DECIM_W = 8
);
  logic [VAL_RES-1:0] sample;
  logic               sampleValid;
  logic [VAL_RES-1:0] trigLevel;
  logic [VAL_RES-1:0] trigHyst;
  logic [1:0]         trigMode;
  logic [DECIM_W-1:0] decim;
  logic               frameStart;
  logic               colReq;
  logic [VAL_RES-1:0] val;
  logic               valValid;
  logic               armed;
  logic               triggered;
  logic               captureDone;

  // Handshakes: sampleValid qualifies sample for one cycle.
  // colReq is a one-cycle request; valValid is high for exactly one cycle,
  // one cycle after an accepted colReq, and val is stable until the next valValid.
  modport master (
    output sample, sampleValid, trigLevel, trigHyst, trigMode, decim,
           frameStart, colReq,
    input  val, valValid, armed, triggered, captureDone
  );

  modport slave (
    input  sample, sampleValid, trigLevel, trigHyst, trigMode, decim,
           frameStart, colReq,
    output val, valValid, armed, triggered, captureDone
  );
endinterface

// File: rtl/scope_trigger_capture.sv
// Oscilloscope trigger and frame capture: decimates the ADC stream, waits for a rising
// edge with hysteresis, stores one frame and serves it column by column to the display.
module scope_trigger_capture #(
  parameter int VAL_RES      = 16,
  parameter int WIDTH        = 640,
  parameter int IDX_W        = 10,
  parameter int DECIM_W      = 8,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                    clkWR,
  input  logic                    rst,
  scope_trigger_capture_if.slave  bus,
  output logic [2:0]              dbg_state_o
);

  localparam int                TO_W     = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(AUTO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    READY     = 3'd4,
    HOLD      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]   rd_addr;
  logic [VAL_RES-1:0] val_q, val_d;
  logic               val_valid_q, val_valid_d;
  logic               armed_q, triggered_q, done_q;
  logic [VAL_RES-1:0] mem [WIDTH];

  logic               dec_hit, arm_hit, trig_hit, wr_en;
  logic               mode_auto, mode_single, serving;
  logic [VAL_RES-1:0] low_thresh;

  // Decimation counter runs in every state so the sample phase is not disturbed by capture.
  assign dec_hit   = bus.sampleValid && (dec_cnt_q >= bus.decim);
  assign dec_cnt_d = !bus.sampleValid ? dec_cnt_q :
                     (dec_hit ? '0 : dec_cnt_q + DECIM_W'(1));

  assign low_thresh = (bus.trigLevel > bus.trigHyst) ? (bus.trigLevel - bus.trigHyst) : '0;
  // A zero threshold would otherwise never arm; a sample of exactly 0 arms in that case.
  assign arm_hit    = dec_hit && ((bus.sample < low_thresh) || (bus.sample == '0));
  assign trig_hit   = dec_hit && (bus.sample >= bus.trigLevel);

  assign mode_auto   = (bus.trigMode == 2'b00);
  assign mode_single = (bus.trigMode == 2'b10);
  assign serving     = ((state_q == READY) || (state_q == HOLD)) && bus.colReq;
  assign rd_addr     = bus.frameStart ? '0 : rd_idx_q;

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    wr_en       = 1'b0;
    val_d       = val_q;
    val_valid_d = 1'b0;

    if ((state_q == READY) || (state_q == HOLD)) begin
      if (bus.frameStart) rd_idx_d = '0;
      if (bus.colReq) begin
        val_d       = mem[rd_addr];
        val_valid_d = 1'b1;
        rd_idx_d    = (rd_addr == LAST_IDX) ? '0 : rd_addr + IDX_W'(1);
      end
    end

    case (state_q)
      IDLE: state_d = ARMED;

      ARMED, WAIT_TRIG: begin
        if (dec_hit) begin
          if ((state_q == WAIT_TRIG) && trig_hit) begin
            // The triggering sample itself becomes column 0.
            state_d  = CAPTURE;
            wr_en    = 1'b1;
            wr_idx_d = IDX_W'(1);
            to_cnt_d = '0;
          end else if (mode_auto && (to_cnt_q >= TO_LAST)) begin
            state_d  = CAPTURE;
            wr_idx_d = '0;
            to_cnt_d = '0;
          end else begin
            if ((state_q == ARMED) && arm_hit) state_d = WAIT_TRIG;
            if (to_cnt_q < TO_LAST) to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end

      CAPTURE: begin
        if (dec_hit) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d  = READY;
            wr_idx_d = '0;
            rd_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end

      READY: begin
        if (serving && (rd_addr == LAST_IDX)) state_d = mode_single ? HOLD : ARMED;
      end

      HOLD: state_d = HOLD;

      default: state_d = IDLE;
    endcase
  end

  // Frame buffer kept reset-free so it maps onto block RAM.
  always_ff @(posedge clkWR) begin
    if (wr_en) mem[wr_idx_q] <= bus.sample;
  end

  always_ff @(posedge clkWR) begin
    if (rst) begin
      state_q     <= IDLE;
      dec_cnt_q   <= '0;
      to_cnt_q    <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      val_q       <= '0;
      val_valid_q <= 1'b0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_cnt_q   <= dec_cnt_d;
      to_cnt_q    <= to_cnt_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      val_q       <= val_d;
      val_valid_q <= val_valid_d;
      armed_q     <= (state_d == ARMED)   || (state_d == WAIT_TRIG);
      triggered_q <= (state_d == CAPTURE) || (state_d == READY);
      done_q      <= (state_d == READY)   || (state_d == HOLD);
    end
  end

  assign bus.val         = val_q;
  assign bus.valValid    = val_valid_q;
  assign bus.armed       = armed_q;
  assign bus.triggered   = triggered_q;
  assign bus.captureDone = done_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture: table of capture scenarios plus hand-written
// sequences for decimation, single/hold reads, reset abort and zero threshold.
module tb_scope_trigger_capture;
  localparam int VR = 16;
  localparam int W  = 8;
  localparam int IW = 3;
  localparam int DW = 8;
  localparam int AT = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd5;

  logic       clkWR = 1'b0;
  logic       rst   = 1'b1;
  logic [2:0] dbg_state;

  always #5 clkWR = ~clkWR;

  scope_trigger_capture_if #(.VAL_RES(VR), .DECIM_W(DW)) bus ();

  scope_trigger_capture #(
    .VAL_RES(VR), .WIDTH(W), .IDX_W(IW), .DECIM_W(DW), .AUTO_TIMEOUT(AT)
  ) dut (
    .clkWR      (clkWR),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [VR-1:0] exp_q[$];

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [15:0] lvl;
    logic [15:0] hyst;
    logic [7:0] decim;
    logic [15:0] start;
    logic [15:0] step;
    logic [15:0] exp_first;
    logic [15:0] exp_step;
    logic [2:0] exp_end;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sampleValid = 1'b0;
    bus.colReq = 1'b0;
    bus.frameStart = 1'b0;
    @(negedge clkWR);
    @(negedge clkWR);
    rst = 1'b0;
    @(negedge clkWR);
  endtask

  task automatic configure(input logic [1:0] mode, input logic [15:0] lvl,
                           input logic [15:0] hyst, input logic [7:0] decim);
    bus.trigMode  = mode;
    bus.trigLevel = lvl;
    bus.trigHyst  = hyst;
    bus.decim     = decim;
  endtask

  task automatic feed_one(input logic [15:0] v);
    bus.sample = v;
    bus.sampleValid = 1'b1;
    @(negedge clkWR);
    bus.sampleValid = 1'b0;
  endtask

  task automatic feed_ramp(input string name, input logic [15:0] start, input logic [15:0] step);
    for (int k = 0; k < 100; k++) begin
      bus.sample = start + 16'(k) * step;
      bus.sampleValid = 1'b1;
      @(negedge clkWR);
      if (bus.captureDone) break;
    end
    bus.sampleValid = 1'b0;
    chk({name, "_capture_done"}, {31'd0, bus.captureDone}, 32'd1);
    chk({name, "_triggered"}, {31'd0, bus.triggered}, 32'd1);
  endtask

  task automatic read_col(input string name, input logic fs);
    logic [VR-1:0] e;
    e = exp_q.pop_front();
    bus.colReq = 1'b1;
    bus.frameStart = fs;
    @(negedge clkWR);
    bus.colReq = 1'b0;
    bus.frameStart = 1'b0;
    chk({name, "_valValid"}, {31'd0, bus.valValid}, 32'd1);
    chk({name, "_val"}, {16'd0, bus.val}, {16'd0, e});
    @(negedge clkWR);
  endtask

  initial begin
    bus.sample = '0;
    bus.sampleValid = 1'b0;
    bus.trigLevel = '0;
    bus.trigHyst = '0;
    bus.trigMode = 2'b01;
    bus.decim = '0;
    bus.frameStart = 1'b0;
    bus.colReq = 1'b0;

    //            name           mode   lvl       hyst      dec  start     step      first     estep     end
    vecs[0] = '{"normal_ramp",   2'b01, 16'h8000, 16'h0100, 8'd0, 16'h7000, 16'h0800, 16'h8000, 16'h0800, S_ARMED};
    vecs[1] = '{"mode11_ramp",   2'b11, 16'h8000, 16'h0100, 8'd0, 16'h7000, 16'h0800, 16'h8000, 16'h0800, S_ARMED};
    vecs[2] = '{"zero_thresh",   2'b01, 16'h0010, 16'h0100, 8'd0, 16'h0000, 16'h0004, 16'h0010, 16'h0004, S_ARMED};
    vecs[3] = '{"decim1_ramp",   2'b01, 16'h8000, 16'h0100, 8'd1, 16'h7000, 16'h0400, 16'h8400, 16'h0800, S_ARMED};
    vecs[4] = '{"single_ramp",   2'b10, 16'h4000, 16'h1000, 8'd0, 16'h2000, 16'h1000, 16'h4000, 16'h1000, S_HOLD};
    vecs[5] = '{"auto_const_lo", 2'b00, 16'h8000, 16'h0100, 8'd0, 16'h1000, 16'h0000, 16'h1000, 16'h0000, S_ARMED};
    vecs[6] = '{"auto_const_hi", 2'b00, 16'h8000, 16'h0100, 8'd0, 16'h9000, 16'h0000, 16'h9000, 16'h0000, S_ARMED};

    // Reset state while rst is held, then arming one cycle after release
    @(negedge clkWR);
    @(negedge clkWR);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("rst_val", {16'd0, bus.val}, 32'd0);
    chk("rst_flags", {28'd0, bus.valValid, bus.armed, bus.triggered, bus.captureDone}, 32'd0);
    rst = 1'b0;
    @(negedge clkWR);
    chk("post_rst_state", {29'd0, dbg_state}, {29'd0, S_ARMED});
    chk("post_rst_armed", {31'd0, bus.armed}, 32'd1);

    // Table-driven capture scenarios
    for (int v = 0; v < 7; v++) begin
      do_reset();
      configure(vecs[v].mode, vecs[v].lvl, vecs[v].hyst, vecs[v].decim);
      feed_ramp(vecs[v].name, vecs[v].start, vecs[v].step);
      exp_q.delete();
      for (int i = 0; i < W; i++) exp_q.push_back(vecs[v].exp_first + 16'(i) * vecs[v].exp_step);
      for (int i = 0; i < W; i++) read_col(vecs[v].name, 1'b0);
      chk({vecs[v].name, "_end_state"}, {29'd0, dbg_state}, {29'd0, vecs[v].exp_end});
    end

    // decim=3, sampleValid every other cycle, data counting on valid cycles only
    begin
      logic [15:0] cnt;
      do_reset();
      configure(2'b01, 16'h0010, 16'h0008, 8'd3);
      cnt = 16'd0;
      for (int c = 0; c < 400; c++) begin
        if (c % 2 == 1) begin
          bus.sample = cnt;
          bus.sampleValid = 1'b1;
          cnt++;
        end else begin
          bus.sample = 16'hFFFF;
          bus.sampleValid = 1'b0;
        end
        @(negedge clkWR);
        if (bus.captureDone) break;
      end
      bus.sampleValid = 1'b0;
      chk("decim3_capture_done", {31'd0, bus.captureDone}, 32'd1);
      exp_q.delete();
      for (int i = 0; i < W; i++) exp_q.push_back(16'h0013 + 16'(4 * i));
      for (int i = 0; i < W; i++) read_col("decim3", 1'b0);
    end

    // Single mode: frameStart together with colReq, then wrap inside HOLD
    begin
      int idx_seq[12] = '{0, 1, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
      do_reset();
      configure(2'b10, 16'h4000, 16'h1000, 8'd0);
      feed_ramp("hold", 16'h2000, 16'h1000);
      exp_q.delete();
      for (int i = 0; i < 12; i++) exp_q.push_back(16'h4000 + 16'(idx_seq[i]) * 16'h1000);
      for (int i = 0; i < 12; i++) read_col("hold_seq", (i == 2));
      chk("hold_state", {29'd0, dbg_state}, {29'd0, S_HOLD});
      chk("hold_done_flag", {31'd0, bus.captureDone}, 32'd1);
      bus.frameStart = 1'b1;
      @(negedge clkWR);
      bus.frameStart = 1'b0;
      exp_q.push_back(16'h4000);
      read_col("hold_fs_alone", 1'b0);
      chk("hold_state_final", {29'd0, dbg_state}, {29'd0, S_HOLD});
    end

    // colReq ignored while waiting; reset aborts a capture in progress
    do_reset();
    configure(2'b01, 16'h8000, 16'h0100, 8'd0);
    feed_one(16'h7000);
    chk("wait_state", {29'd0, dbg_state}, {29'd0, S_WAIT});
    bus.colReq = 1'b1;
    @(negedge clkWR);
    bus.colReq = 1'b0;
    chk("wait_colreq_valid", {31'd0, bus.valValid}, 32'd0);
    chk("wait_colreq_val", {16'd0, bus.val}, 32'd0);
    feed_one(16'h7800);
    feed_one(16'h8000);
    chk("abort_capt_state", {29'd0, dbg_state}, {29'd0, S_CAPT});
    chk("abort_triggered", {31'd0, bus.triggered}, 32'd1);
    feed_one(16'h8800);
    feed_one(16'h9000);
    feed_one(16'h9800);
    feed_one(16'hA000);
    rst = 1'b1;
    @(negedge clkWR);
    chk("abort_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("abort_outputs", {12'd0, bus.val, bus.valValid, bus.armed, bus.triggered, bus.captureDone}, 32'd0);
    rst = 1'b0;
    @(negedge clkWR);
    chk("abort_rearmed", {29'd0, dbg_state}, {29'd0, S_ARMED});
    bus.colReq = 1'b1;
    @(negedge clkWR);
    bus.colReq = 1'b0;
    chk("abort_no_valvalid", {31'd0, bus.valValid}, 32'd0);

    // Zero low threshold: nonzero samples never arm, a zero sample does
    do_reset();
    configure(2'b01, 16'h0010, 16'h0100, 8'd0);
    for (int i = 0; i < 20; i++) feed_one(16'h0005);
    chk("zero_thr_no_arm", {29'd0, dbg_state}, {29'd0, S_ARMED});
    feed_one(16'h0000);
    chk("zero_thr_arm", {29'd0, dbg_state}, {29'd0, S_WAIT});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
